pad_filter: RTL and testbench

PAD_FILTER -- requirements
Module: pad_filter

---
 rtl/pad_filter_pkg.sv | 23 ++
 rtl/pad_filter_lane.sv | 85 ++++++++
 rtl/pad_filter.sv | 70 +++++++
 tb/tb_pad_filter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_filter_pkg.sv
// Shared constants, lane state and tap-padding rule for pad_filter.
package pad_filter_pkg;

  localparam int unsigned KERNEL_W_MAX_DEFAULT       = 7;
  localparam int unsigned KERNEL_W_WIDTH             = $clog2(KERNEL_W_MAX_DEFAULT + 1);
  localparam int unsigned INDEX_IS_1X1_DEFAULT       = 0;
  localparam int unsigned INDEX_IS_COLS_1_K2_DEFAULT = 3;

  // All-zero encodes row start: col 0, tail idle.
  typedef struct packed {
    logic [KERNEL_W_WIDTH-1:0] col;
    logic                      tail;
    logic [KERNEL_W_WIDTH-1:0] t;
  } lane_state_t;

  // Tap j survives unless beyond the kernel, in the left pad or in the right pad.
  function automatic logic tap_kept(input int j, input int kw_1, input int half,
                                    input lane_state_t s);
    tap_kept = (j <= kw_1) && (j + int'(s.col) >= half) &&
               (!s.tail || (j + int'(s.t) <= 2 * half));
  endfunction

endpackage

// File: rtl/pad_filter_lane.sv
// One lane of pad_filter: column/tail counters plus registered tap and partial-sum masks.
// Honours PAD_FILTER_1X1_EN (1x1 beats bypass padding).
module pad_filter_lane
  import pad_filter_pkg::*;
#(
  parameter int unsigned LANE_IDX = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      aclken,
  input  logic                      i_start,
  input  logic [KERNEL_W_WIDTH-1:0] i_kw_1,
  input  logic [KERNEL_W_WIDTH-1:0] i_half,
  input  logic                      i_valid,
  input  logic                      i_cols_flag,
  input  logic                      i_1x1_flag,
  output logic                      o_mask_full,
  output logic                      o_mask_partial
);

  lane_state_t r_state;
  lane_state_t w_beat;
  lane_state_t w_next;
  logic        w_last;
  logic        w_full;
  logic        w_partial;

  // State seen by this beat (start forces row start), its masks and the follow-on state.
  always_comb begin
    w_beat    = r_state;
    w_next    = '0;
    w_last    = 1'b0;
    w_full    = 1'b0;
    w_partial = 1'b0;
    if (i_start) begin
      w_beat = '0;
    end
    if (i_cols_flag) begin
      w_beat.tail = 1'b1;
      w_beat.t    = '0;
    end
    w_last = w_beat.tail && (w_beat.t == i_half);
    w_full = tap_kept(int'(LANE_IDX), int'(i_kw_1), int'(i_half), w_beat);
    for (int k = 0; k < int'(LANE_IDX); k++) begin
      if (tap_kept(k, int'(i_kw_1), int'(i_half), w_beat)) begin
        w_partial = 1'b1;
      end
    end
    w_partial = w_partial && (int'(LANE_IDX) <= int'(i_kw_1));
    if (!w_last) begin
      w_next.col  = (w_beat.col >= i_half) ? i_half : w_beat.col + KERNEL_W_WIDTH'(1);
      w_next.tail = w_beat.tail;
      w_next.t    = w_beat.tail ? w_beat.t + KERNEL_W_WIDTH'(1) : '0;
    end
`ifdef PAD_FILTER_1X1_EN
    if (i_1x1_flag) begin
      w_next    = '0;
      w_full    = (LANE_IDX == 0);
      w_partial = 1'b0;
    end
`endif
  end

`ifndef PAD_FILTER_1X1_EN
  logic w_unused_1x1;
  assign w_unused_1x1 = i_1x1_flag;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= '0;
      o_mask_full    <= 1'b0;
      o_mask_partial <= 1'b0;
    end else if (aclken) begin
      if (i_valid) begin
        r_state        <= w_next;
        o_mask_full    <= w_full;
        o_mask_partial <= w_partial;
      end else if (i_start) begin
        r_state <= '0;
      end
    end
  end

endmodule

// File: rtl/pad_filter.sv
// Convolution edge-padding mask generator: shared kernel width, one counter lane per tap.
// Optional macro PAD_FILTER_1X1_EN enables the 1x1 bypass mode.
module pad_filter
  import pad_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned KERNEL_W_MAX       = KERNEL_W_MAX_DEFAULT,
  parameter int unsigned TUSER_WIDTH        = 4,
  parameter int unsigned INDEX_IS_1x1       = INDEX_IS_1X1_DEFAULT,
  parameter int unsigned INDEX_IS_COLS_1_K2 = INDEX_IS_COLS_1_K2_DEFAULT
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      aclken,
  input  logic                      start,
  input  logic [KERNEL_W_WIDTH-1:0] kernel_w_1_in,
  input  logic                      valid_last   [KERNEL_W_MAX-1:0],
  input  logic [TUSER_WIDTH-1:0]    user         [KERNEL_W_MAX-1:0],
  output logic                      mask_partial [KERNEL_W_MAX-1:1],
  output logic                      mask_full    [KERNEL_W_MAX-1:0]
);

  localparam int unsigned unused_data_width = DATA_WIDTH;

  logic [KERNEL_W_WIDTH-1:0] r_kw_1;
  logic [KERNEL_W_WIDTH-1:0] w_kw_1;
  logic [KERNEL_W_WIDTH-1:0] w_half;
  logic                      w_partial       [KERNEL_W_MAX-1:0];
  logic [KERNEL_W_MAX-1:0]   w_unused_user;
  logic                      w_unused_partial0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_kw_1 <= '0;
    end else if (aclken && start) begin
      r_kw_1 <= kernel_w_1_in;
    end
  end

  // A beat coinciding with start already uses the new kernel width.
  assign w_kw_1 = (aclken && start) ? kernel_w_1_in : r_kw_1;
  assign w_half = w_kw_1 >> 1;

  for (genvar i = 0; i < KERNEL_W_MAX; i++) begin : g_lane
    pad_filter_lane #(
      .LANE_IDX(i)
    ) u_lane (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .aclken        (aclken),
      .i_start       (start),
      .i_kw_1        (w_kw_1),
      .i_half        (w_half),
      .i_valid       (valid_last[i]),
      .i_cols_flag   (user[i][INDEX_IS_COLS_1_K2]),
      .i_1x1_flag    (user[i][INDEX_IS_1x1]),
      .o_mask_full   (mask_full[i]),
      .o_mask_partial(w_partial[i])
    );
    assign w_unused_user[i] = ^user[i];
  end

  for (genvar i = 1; i < KERNEL_W_MAX; i++) begin : g_partial
    assign mask_partial[i] = w_partial[i];
  end

  // Lane 0 has no lower taps, so its partial mask has no output.
  assign w_unused_partial0 = w_partial[0];

endmodule

// File: tb/tb_pad_filter.sv
// Self-checking bench for pad_filter: per-lane behavioural model plus literal mask patterns.
module tb_pad_filter;

  localparam int KW = 7;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       aclken;
  logic       start;
  logic [2:0] kernel_w_1_in;
  logic       valid_last   [KW-1:0];
  logic [3:0] user         [KW-1:0];
  logic       mask_partial [KW-1:1];
  logic       mask_full    [KW-1:0];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: beats since row start, tail flag and tail distance, per lane.
  int m_kw;
  int m_beats [KW];
  bit m_tail  [KW];
  int m_t     [KW];
  bit exp_full [KW];
  bit exp_part [KW];

  logic [6:0] dut_full;
  logic [6:1] dut_part;

  always #5 aclk = ~aclk;

  pad_filter #(
    .DATA_WIDTH        (16),
    .KERNEL_W_MAX      (7),
    .TUSER_WIDTH       (4),
    .INDEX_IS_1x1      (0),
    .INDEX_IS_COLS_1_K2(3)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .aclken       (aclken),
    .start        (start),
    .kernel_w_1_in(kernel_w_1_in),
    .valid_last   (valid_last),
    .user         (user),
    .mask_partial (mask_partial),
    .mask_full    (mask_full)
  );

  always_comb begin
    dut_full = '0;
    dut_part = '0;
    for (int i = 0; i < KW; i++) dut_full[i] = mask_full[i];
    for (int i = 1; i < KW; i++) dut_part[i] = mask_partial[i];
  end

  function automatic bit kept(int j, int kw, int half, int col, bit tail, int t);
    if (j > kw) return 1'b0;
    if (j < half - col) return 1'b0;
    if (tail && (j + t > 2 * half)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_kw = 0;
    for (int i = 0; i < KW; i++) begin
      m_beats[i] = 0; m_tail[i] = 1'b0; m_t[i] = 0;
      exp_full[i] = 1'b0; exp_part[i] = 1'b0;
    end
  endtask

  // Apply the inputs present at the clock edge just taken.
  task automatic model_edge();
    int  half, col, t;
    bit  tl;
    if (!aclken) return;
    if (start) begin
      m_kw = int'(kernel_w_1_in);
      for (int i = 0; i < KW; i++) begin
        m_beats[i] = 0; m_tail[i] = 1'b0; m_t[i] = 0;
      end
    end
    half = m_kw / 2;
    for (int i = 0; i < KW; i++) begin
      if (valid_last[i]) begin
`ifdef PAD_FILTER_1X1_EN
        if (user[i][0]) begin
          exp_full[i] = (i == 0);
          exp_part[i] = 1'b0;
          m_beats[i] = 0; m_tail[i] = 1'b0; m_t[i] = 0;
          continue;
        end
`endif
        tl  = m_tail[i] || user[i][3];
        t   = user[i][3] ? 0 : m_t[i];
        col = (m_beats[i] < half) ? m_beats[i] : half;
        exp_full[i] = kept(i, m_kw, half, col, tl, t);
        exp_part[i] = 1'b0;
        for (int k = 0; k < i; k++)
          if (kept(k, m_kw, half, col, tl, t)) exp_part[i] = 1'b1;
        if (i > m_kw) exp_part[i] = 1'b0;
        if (tl && t == half) begin
          m_beats[i] = 0; m_tail[i] = 1'b0; m_t[i] = 0;
        end else begin
          m_beats[i] = m_beats[i] + 1;
          m_tail[i]  = tl;
          m_t[i]     = tl ? t + 1 : 0;
        end
      end
    end
  endtask

  // Every cycle: DUT masks against the model.
  always @(negedge aclk) begin : compare
    logic [6:0] ef;
    logic [6:1] ep;
    if (chk_en) begin
      ef = '0;
      ep = '0;
      for (int i = 0; i < KW; i++) ef[i] = exp_full[i];
      for (int i = 1; i < KW; i++) ep[i] = exp_part[i];
      checks++;
      if (dut_full !== ef) begin
        failures++;
        $display("FAIL model_full t=%0t got=%b want=%b", $time, dut_full, ef);
      end
      checks++;
      if (dut_part !== ep) begin
        failures++;
        $display("FAIL model_partial t=%0t got=%b want=%b", $time, dut_part, ep);
      end
    end
  end

  task automatic check_lit(input string name, input logic [6:0] ef, input logic [6:1] ep);
    checks++;
    if (dut_full !== ef) begin
      failures++;
      $display("FAIL %s mask_full got=%b want=%b", name, dut_full, ef);
    end
    checks++;
    if (dut_part !== ep) begin
      failures++;
      $display("FAIL %s mask_partial got=%b want=%b", name, dut_part, ep);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), then return to idle at the next posedge+1.
  task automatic step(input bit st, input int kw, input logic [6:0] v, input logic [6:0] c,
                      input logic [6:0] x, input bit en);
    start         = st;
    kernel_w_1_in = 3'(kw);
    aclken        = en;
    for (int i = 0; i < KW; i++) begin
      valid_last[i] = v[i];
      user[i]       = {c[i], 2'b00, x[i]};
    end
    @(posedge aclk);
    model_edge();
    #1;
    start  = 1'b0;
    aclken = 1'b1;
    for (int i = 0; i < KW; i++) begin
      valid_last[i] = 1'b0;
      user[i]       = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 7'h00, 7'h00, 7'h00, 1'b1);
  endtask

  localparam logic [6:0] ALL = 7'h7F;
  localparam logic [6:0] NONE = 7'h00;

  initial begin
    start = 1'b0; aclken = 1'b1; kernel_w_1_in = '0;
    for (int i = 0; i < KW; i++) begin
      valid_last[i] = 1'b0; user[i] = '0;
    end
    model_reset();
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #20;
    check_lit("reset", 7'b0000000, 6'b000000);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    chk_en = 1'b1;
    idle(3);
    check_lit("idle_after_reset", 7'b0000000, 6'b000000);

    // Full row with kw_1=4 (half=2)
    step(1'b1, 4, NONE, NONE, NONE, 1'b1);
    check_lit("start_no_beat", 7'b0000000, 6'b000000);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("col0", 7'b0011100, 6'b001100);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("col1", 7'b0011110, 6'b001110);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("col2", 7'b0011111, 6'b001111);
    step(1'b0, 4, ALL, ALL, NONE, 1'b1);
    check_lit("tail_t0", 7'b0011111, 6'b001111);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("tail_t1", 7'b0001111, 6'b001111);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("tail_t2", 7'b0000111, 6'b001111);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("next_row_col0", 7'b0011100, 6'b001100);
    idle(2);
    check_lit("hold_between_beats", 7'b0011100, 6'b001100);

    // Clock enable low swallows the beat
    step(1'b0, 4, ALL, NONE, NONE, 1'b0);
    check_lit("aclken_low", 7'b0011100, 6'b001100);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("col1_after_hold", 7'b0011110, 6'b001110);

    // Start mid-row aborts the row
    step(1'b1, 4, NONE, NONE, NONE, 1'b1);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    check_lit("restart_col0", 7'b0011100, 6'b001100);

    // Start coinciding with a beat uses the new kw_1=2 (half=1)
    step(1'b1, 2, ALL, NONE, NONE, 1'b1);
    check_lit("start_beat_kw2", 7'b0000110, 6'b000010);
    step(1'b0, 2, ALL, NONE, NONE, 1'b1);
    check_lit("kw2_col1", 7'b0000111, 6'b000011);

    // half=0: flagged beat is itself the last column
    step(1'b1, 1, ALL, ALL, NONE, 1'b1);
    check_lit("half0_last", 7'b0000001, 6'b000001);
    step(1'b0, 1, ALL, NONE, NONE, 1'b1);
    check_lit("half0_next", 7'b0000011, 6'b000001);

    // Independent lanes: only lanes 0..3 see the first beat
    step(1'b1, 4, NONE, NONE, NONE, 1'b1);
    step(1'b0, 4, 7'b0001111, NONE, NONE, 1'b1);
    step(1'b0, 4, ALL, NONE, NONE, 1'b1);
    step(1'b0, 4, 7'b1010101, 7'b0100100, NONE, 1'b1);
    idle(1);

    // 1x1 flag on every beat
    step(1'b1, 4, NONE, NONE, NONE, 1'b1);
`ifdef PAD_FILTER_1X1_EN
    for (int b = 0; b < 3; b++) begin
      step(1'b0, 4, ALL, NONE, ALL, 1'b1);
      check_lit("one_by_one", 7'b0000001, 6'b000000);
    end
`else
    step(1'b0, 4, ALL, NONE, ALL, 1'b1);
    check_lit("1x1_ignored_col0", 7'b0011100, 6'b001100);
    step(1'b0, 4, ALL, NONE, ALL, 1'b1);
    check_lit("1x1_ignored_col1", 7'b0011110, 6'b001110);
`endif

    // Mixed stimulus sweep checked by the model
    for (int n = 0; n < 300; n++) begin
      logic [6:0] v, c, x;
      bit st, en;
      st = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 7) != 0);
      v  = 7'($urandom);
      c  = 7'($urandom) & 7'($urandom) & 7'($urandom);
      x  = 7'($urandom) & 7'($urandom);
      step(st, $urandom_range(0, 7), v, c, x, en);
    end

    // Asynchronous reset mid-cycle
    #2 aresetn = 1'b0;
    model_reset();
    #1;
    check_lit("async_reset", 7'b0000000, 6'b000000);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    idle(2);
    check_lit("after_async_reset", 7'b0000000, 6'b000000);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
